hamming_classifier: RTL and testbench

HAMMING_CLASSIFIER -- requirements
Module: hamming_classifier

---
 rtl/hamming_classifier_pkg.sv | 25 ++
 rtl/hamming_classifier_popcount.sv | 29 ++
 rtl/hamming_classifier.sv | 155 +++++++++++++++
 tb/tb_hamming_classifier.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hamming_classifier_pkg.sv
// ----------------------------------------------------------------------------
// hamming_classifier_pkg : FSM state type, default sizes and derived widths.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hamming_classifier_pkg;

   localparam int DEF_DI_PARALLEL_W_BITS = 64;
   localparam int DEF_N_CLASSES          = 8;
   localparam int DEF_N_FRAMES           = 3;

   localparam int CLASS_ID_W  = $clog2(DEF_N_CLASSES);
   localparam int FRAME_IDX_W = (DEF_N_FRAMES > 1) ? $clog2(DEF_N_FRAMES) : 1;
   localparam int DIST_W      = $clog2(DEF_N_FRAMES * DEF_DI_PARALLEL_W_BITS + 1);

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/hamming_classifier_popcount.sv
// ----------------------------------------------------------------------------
// popcount_vec : combinational population count of (a XOR b).
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module popcount_vec #(
   parameter int WIDTH = 64,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] diff;

   assign diff = a ^ b;

   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + CNT_W'(diff[i]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/hamming_classifier.sv
// ----------------------------------------------------------------------------
// hamming_classifier : nearest-class search by Hamming distance over framed
// hypervectors read from an external class ROM. Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hamming_classifier
   import hamming_classifier_pkg::*;
#(
   parameter int DI_PARALLEL_W_BITS = DEF_DI_PARALLEL_W_BITS,
   parameter int N_CLASSES          = DEF_N_CLASSES,
   parameter int N_FRAMES           = DEF_N_FRAMES,
   localparam int CID_W  = $clog2(N_CLASSES),
   localparam int FIX_W  = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
   localparam int DST_W  = $clog2(N_FRAMES * DI_PARALLEL_W_BITS + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DI_PARALLEL_W_BITS-1:0] query_frame,
   input  logic                          query_valid,
   output logic                          query_ready,
   output logic [CID_W-1:0]              frame_id,
   output logic [FIX_W-1:0]              frame_index,
   input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
   output logic [CID_W-1:0]              class_id_out,
   output logic [DST_W-1:0]              distance_out,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int PCNT_W = $clog2(DI_PARALLEL_W_BITS + 1);

   state_t state;
   state_t state_nxt;

   logic [FIX_W-1:0]              load_cnt;
   logic [DI_PARALLEL_W_BITS-1:0] query_mem [N_FRAMES];
   logic [DI_PARALLEL_W_BITS-1:0] query_sel;
   logic [PCNT_W-1:0]             pcnt;
   logic [DST_W-1:0]              acc;
   logic [DST_W-1:0]              class_dist;
   logic [DST_W-1:0]              best_dist;
   logic [CID_W-1:0]              best_id;

   logic load_fire;
   logic load_last;
   logic cmp_frame_last;
   logic cmp_last;

   assign load_fire      = (state == ST_LOAD) && query_valid;
   assign load_last      = load_fire && (load_cnt == FIX_W'(N_FRAMES - 1));
   assign cmp_frame_last = (frame_index == FIX_W'(N_FRAMES - 1));
   assign cmp_last       = (state == ST_COMPARE) && cmp_frame_last &&
                           (frame_id == CID_W'(N_CLASSES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      query_ready = 1'b0;
      out_valid   = 1'b0;
      case (state)
         ST_LOAD: begin
            query_ready = 1'b1;
            if (load_last) begin
               state_nxt = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            if (cmp_last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_LOAD;
            end
         end
         default: begin
            state_nxt = ST_LOAD;
         end
      endcase
   end

   // Query slots carry no reset; load_cnt alone defines which are meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_FRAMES; i++) begin
         if (load_fire && (load_cnt == FIX_W'(i))) begin
            query_mem[i] <= query_frame;
         end
      end
   end

   always_comb begin
      query_sel = '0;
      for (int i = 0; i < N_FRAMES; i++) begin
         if (frame_index == FIX_W'(i)) begin
            query_sel = query_mem[i];
         end
      end
   end

   popcount_vec #(
      .WIDTH (DI_PARALLEL_W_BITS)
   ) u_popcount (
      .a     (query_sel),
      .b     (class_vec_in),
      .count (pcnt)
   );

   assign class_dist = acc + DST_W'(pcnt);

   // Strict less-than keeps the lowest class index on equal distances.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_cnt    <= '0;
         acc         <= '0;
         best_dist   <= '0;
         best_id     <= '0;
         frame_id    <= '0;
         frame_index <= '0;
      end else begin
         if (load_fire) begin
            load_cnt <= load_last ? '0 : load_cnt + FIX_W'(1);
         end
         if (state == ST_COMPARE) begin
            if (cmp_frame_last) begin
               frame_index <= '0;
               frame_id    <= cmp_last ? '0 : frame_id + CID_W'(1);
               acc         <= '0;
               if ((frame_id == '0) || (class_dist < best_dist)) begin
                  best_dist <= class_dist;
                  best_id   <= frame_id;
               end
            end else begin
               frame_index <= frame_index + FIX_W'(1);
               acc         <= class_dist;
            end
         end
      end
   end

   assign class_id_out = best_id;
   assign distance_out = best_dist;

endmodule

`default_nettype wire

// File: tb/tb_hamming_classifier.sv
// ----------------------------------------------------------------------------
// tb_hamming_classifier : table-driven bench with a behavioural class ROM.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hamming_classifier;
   import hamming_classifier_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] query_frame = '0;
   logic        query_valid = 1'b0;
   logic        query_ready;
   logic [2:0]  frame_id;
   logic [1:0]  frame_index;
   logic [63:0] class_vec_in;
   logic [2:0]  class_id_out;
   logic [7:0]  distance_out;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int errors = 0;
   int checks = 0;
   int rom_mode = 0;

   typedef struct {
      logic [63:0] q0;
      logic [63:0] q1;
      logic [63:0] q2;
      int          mode;
      int          exp_id;
      int          exp_dist;
   } vec_t;

   vec_t tbl [8];

   hamming_classifier dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .query_frame  (query_frame),
      .query_valid  (query_valid),
      .query_ready  (query_ready),
      .frame_id     (frame_id),
      .frame_index  (frame_index),
      .class_vec_in (class_vec_in),
      .class_id_out (class_id_out),
      .distance_out (distance_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mask(input int n);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Class c: every frame has its lower 8*c bits set; mode 1 makes class 5 a copy of class 2.
   assign class_vec_in = (rom_mode == 1 && frame_id == 3'd5) ? mask(16) : mask(8 * int'(frame_id));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic send_query(input vec_t v);
      logic [63:0] fr [3];
      int n;
      fr[0] = v.q0; fr[1] = v.q1; fr[2] = v.q2;
      for (int f = 0; f < 3; f++) begin
         query_frame = fr[f];
         query_valid = 1'b1;
         n = 0;
         while (!query_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) check("ready_timeout", 64'(n), 64'd0);
         @(negedge clk);
      end
      // Garbage offered while busy must never be captured.
      query_frame = {$urandom, $urandom};
      query_valid = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int hold, input string tag);
      int k;
      int seq_bad;
      logic [2:0] id_snap;
      logic [7:0] dist_snap;
      rom_mode = v.mode;
      send_query(v);
      check({tag, "_busy_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy_ready"}, 64'(query_ready), 64'd0);
      k = 0;
      seq_bad = 0;
      while (!out_valid && k < 100) begin
         if (k < 24 && (frame_id != 3'(k / 3) || frame_index != 2'(k % 3))) seq_bad = 1;
         @(negedge clk);
         k++;
      end
      check({tag, "_latency"}, 64'(k), 64'd24);
      check({tag, "_sequence"}, 64'(seq_bad), 64'd0);
      check({tag, "_class"}, 64'(class_id_out), 64'(v.exp_id));
      check({tag, "_dist"}, 64'(distance_out), 64'(v.exp_dist));
      if (hold > 0) begin
         id_snap = class_id_out;
         dist_snap = distance_out;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold"}, {class_id_out, distance_out, out_valid, query_ready},
                  {id_snap, dist_snap, 1'b1, 1'b0});
         end
      end
      query_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_back_ready"}, 64'(query_ready), 64'd1);
      check({tag, "_back_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_back_frame"}, {frame_id, frame_index}, 5'd0);
   endtask

   initial begin
      tbl[0] = '{64'h0, 64'h0, 64'h0, 0, 0, 0};
      tbl[1] = '{64'hFF_FFFF, 64'hFF_FFFF, 64'hFF_FFFF, 0, 3, 0};
      tbl[2] = '{'1, '1, '1, 0, 7, 24};
      tbl[3] = '{64'hFFFF, 64'hFFFF, 64'hFFFF, 1, 2, 0};
      tbl[4] = '{64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF, 0, 5, 0};
      tbl[5] = '{64'h0, 64'hFF, 64'hFFFF, 0, 1, 16};
      tbl[6] = '{64'hFFF, 64'hFFF, 64'hFFF, 0, 1, 12};
      tbl[7] = '{64'hF, 64'hF, 64'hF, 0, 0, 12};

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_query_ready", 64'(query_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_frame_id", 64'(frame_id), 64'd0);
      check("rst_frame_index", 64'(frame_index), 64'd0);
      check("rst_class_id", 64'(class_id_out), 64'd0);
      check("rst_distance", 64'(distance_out), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_vec(tbl[i], (i == 2) ? 10 : 0, $sformatf("vec%0d", i));
      end

      // Reset in the middle of COMPARE abandons the search.
      rom_mode = 0;
      send_query(tbl[2]);
      repeat (10) @(negedge clk);
      check("mid_frame_id", 64'(frame_id), 64'd3);
      check("mid_frame_index", 64'(frame_index), 64'd1);
      rst_n = 1'b0;
      query_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(query_ready), 64'd1);
      check("mid_rst_frame_id", 64'(frame_id), 64'd0);
      check("mid_rst_frame_index", 64'(frame_index), 64'd0);
      check("mid_rst_distance", 64'(distance_out), 64'd0);
      run_vec(tbl[1], 0, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
